run_ctrl: RTL
=============

Name: run_ctrl

Overview:
- Parametrised run/step controller for the simple processor.
- Generates the `work` enable that gates the datapath.
- Supports three modes: free-run (toggled by `change`), halt, and multi-cycle stepping that runs for exactly `step_count` cycles.
- `change` and `step` are treated as edge events, so a held button produces one event.
- Adds a step-done pulse, a remaining-count readout and an optional PC breakpoint.

Parameters:
- CNT_W, 8, width of `step_count` and of the internal step counter.
- PC_W, 8, width of `pc` and `bp_addr`; used only with RUN_CTRL_BP_EN.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- change  input  1  run/halt toggle request, level; rising edge is the event.
- step  input  1  step request, level; rising edge is the event.
- step_count  input  CNT_W  number of cycles to execute per step; sampled on the step event.
- work  output  1  datapath enable.
- halted  output  1  high in HALT.
- step_done  output  1  one-cycle pulse when a step sequence completes normally.
- remaining  output  CNT_W  cycles left in the current step sequence; 0 outside STEP.
- pc  input  PC_W  current program counter (RUN_CTRL_BP_EN only).
- bp_addr  input  PC_W  breakpoint address (RUN_CTRL_BP_EN only).
- bp_en  input  1  breakpoint enable (RUN_CTRL_BP_EN only).
- bp_hit  output  1  one-cycle pulse when the breakpoint halts execution (RUN_CTRL_BP_EN only).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=HALT, counter=0.
  - Edge-detect registers `change_q` and `step_q` cleared to 0.
  - step_done=0, bp_hit=0.
  - Outputs: work=0, halted=1, remaining=0.
- Edge detection:
  - `chg_ev = change & ~change_q`; `stp_ev = step & ~step_q`.
  - `change_q` and `step_q` capture the inputs every clock.
  - Consequence: an input held high across reset release fires one event on the first clock.
- States are HALT, RUN and STEP.
  - `work` = (state==RUN || state==STEP), decoded from the state register.
  - `halted` = (state==HALT).
- HALT transitions:
  - chg_ev -> RUN.
  - Else stp_ev -> STEP, with counter loaded from `step_count`; a `step_count` of 0 loads 1.
  - Simultaneous chg_ev and stp_ev: change wins, goes to RUN, and the step event is discarded.
- RUN transitions:
  - chg_ev -> HALT.
  - stp_ev is ignored.
- STEP transitions:
  - Each clock, counter decrements.
  - When counter==1 at a clock edge -> HALT, counter=0, and step_done=1 for the next cycle.
  - chg_ev -> RUN, counter=0, no step_done (abort to free-run).
  - stp_ev is ignored (no re-arm).
- Step latency: with the step event sampled at edge k, work=1 for exactly N cycles starting after edge k (N = loaded count), and halted=1 after edge k+N.
- remaining: equals the counter in STEP, 0 otherwise; it is the count of work cycles still to come, including the current one.
- step_done and bp_hit are registered pulses, high for one cycle only.
- Reset asserted mid-STEP or mid-RUN: immediate return to the reset values, with no step_done.

Optional Feature:
- RUN_CTRL_BP_EN defined:
  - Ports `pc`, `bp_addr`, `bp_en` and `bp_hit` exist.
  - In RUN or STEP, if bp_en=1 and pc==bp_addr at a clock edge -> HALT, counter=0, bp_hit=1 next cycle, step_done=0.
  - Breakpoint has priority over chg_ev and over normal step completion in the same cycle.
  - No effect in HALT, so that resuming from a breakpoint with change is possible while pc still equals bp_addr: the first compare occurs the cycle after entering RUN. Software must therefore move pc, or clear bp_en, to avoid an immediate re-halt.
- RUN_CTRL_BP_EN undefined: these ports and all related logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset/idle: rst=0 then 1, change=step=0 for 10 cycles -> work=0, halted=1, remaining=0, step_done=0 throughout.
- Multi-step: step_count=3, pulse step high for 5 cycles -> work=1 for exactly 3 cycles, remaining 3,2,1, then halted=1 and step_done high for 1 cycle; holding step high produces no second sequence.
- Zero count and run toggle:
  - step_count=0 with a step event -> exactly 1 work cycle and step_done.
  - change rising -> work stays 1 indefinitely; second change rising -> HALT the cycle after the edge.
- Simultaneous/abort:
  - change and step rise on the same edge in HALT -> RUN, remaining=0.
  - Step with step_count=10, change rising after 4 work cycles -> RUN, no step_done.
- Async reset mid-step: step_count=200, assert rst=0 between edges after 50 cycles -> work=0, remaining=0 immediately, without waiting for clk.
- Breakpoint (RUN_CTRL_BP_EN): bp_en=1, bp_addr=8'h12, RUN with pc counting from 8'h10 -> HALT at the edge where pc=8'h12, bp_hit pulses once, step_done=0.

Source files
------------

// File: rtl/run_ctrl_if.sv
// Handshake bundle between the run controller and the block that drives it.
// With RUN_CTRL_BP_EN defined, the bundle also carries the breakpoint signals.
interface run_ctrl_if #(
    parameter int CNT_W = 8,
    parameter int PC_W  = 8
);
    logic             change;
    logic             step;
    logic [CNT_W-1:0] step_count;
    logic             work;
    logic             halted;
    logic             step_done;
    logic [CNT_W-1:0] remaining;
`ifdef RUN_CTRL_BP_EN
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  bp_addr;
    logic             bp_en;
    logic             bp_hit;
`endif

    modport master (
        output change, step, step_count,
`ifdef RUN_CTRL_BP_EN
        output pc, bp_addr, bp_en,
        input  bp_hit,
`endif
        input  work, halted, step_done, remaining
    );

    modport slave (
        input  change, step, step_count,
`ifdef RUN_CTRL_BP_EN
        input  pc, bp_addr, bp_en,
        output bp_hit,
`endif
        output work, halted, step_done, remaining
    );
endinterface

// File: rtl/run_ctrl.sv
// Run/halt/step controller that produces the datapath work enable.
// Define RUN_CTRL_BP_EN to add the PC breakpoint (pc, bp_addr, bp_en, bp_hit).
module run_ctrl #(
    parameter int CNT_W = 8,
    parameter int PC_W  = 8
) (
    input  logic         clk,
    input  logic         rst,
    run_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {HALT, RUN, STEP} state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             change_q, step_q;
    logic             done_q;
    logic             chg_ev, stp_ev, bp_trip;

    assign chg_ev = bus.change & ~change_q;
    assign stp_ev = bus.step & ~step_q;

`ifdef RUN_CTRL_BP_EN
    logic [PC_W-1:0] pc_cmp;
    logic            hit_q;
    assign pc_cmp     = bus.pc ^ bus.bp_addr;
    // HALT never compares, so change can resume while pc still sits on bp_addr.
    assign bp_trip    = (state != HALT) && bus.bp_en && (pc_cmp == '0);
    assign bus.bp_hit = hit_q;
`else
    assign bp_trip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HALT;
            counter  <= '0;
            change_q <= 1'b0;
            step_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            change_q <= bus.change;
            step_q   <= bus.step;
            done_q   <= 1'b0;
            if (bp_trip) begin
                state   <= HALT;
                counter <= '0;
            end else begin
                case (state)
                    HALT: begin
                        if (chg_ev) begin
                            state <= RUN;
                        end else if (stp_ev) begin
                            state   <= STEP;
                            counter <= (bus.step_count == '0) ? CNT_W'(1) : bus.step_count;
                        end
                    end
                    RUN: begin
                        if (chg_ev) state <= HALT;
                    end
                    STEP: begin
                        // Normal completion outranks an abort landing on the last cycle.
                        if (counter == CNT_W'(1)) begin
                            state   <= HALT;
                            counter <= '0;
                            done_q  <= 1'b1;
                        end else if (chg_ev) begin
                            state   <= RUN;
                            counter <= '0;
                        end else begin
                            counter <= counter - CNT_W'(1);
                        end
                    end
                    default: begin
                        state   <= HALT;
                        counter <= '0;
                    end
                endcase
            end
        end
    end

`ifdef RUN_CTRL_BP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hit_q <= 1'b0;
        else      hit_q <= bp_trip;
    end
`endif

    assign bus.work      = (state == RUN) || (state == STEP);
    assign bus.halted    = (state == HALT);
    assign bus.remaining = (state == STEP) ? counter : '0;
    assign bus.step_done = done_q;
endmodule
